// File: rtl/mux8_1.sv
// Single-bit 8:1 multiplexer built as a gate-level tree of 2:1 muxes,
// with a registered copy of the result for pipeline-stage use.
module mux8_1 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       out,
  output logic       out_q
);

  localparam int unsigned L0_W  = 4;
  localparam int unsigned L1_W  = 2;
  localparam int unsigned SEL_W = 3;

  logic [SEL_W-1:0] sel_n;
  logic [L0_W-1:0]  lvl0;
  logic [L1_W-1:0]  lvl1;
  logic             lvl2;
  logic             out_d;

  assign sel_n = ~sel;

  // Each 2:1 stage is NOT + two ANDs + OR; a low select picks the even input
  for (genvar k = 0; k < L0_W; k++) begin : g_lvl0
    assign lvl0[k] = (in[2*k] & sel_n[0]) | (in[2*k+1] & sel[0]);
  end

  for (genvar k = 0; k < L1_W; k++) begin : g_lvl1
    assign lvl1[k] = (lvl0[2*k] & sel_n[1]) | (lvl0[2*k+1] & sel[1]);
  end

  assign lvl2  = (lvl1[0] & sel_n[2]) | (lvl1[1] & sel[2]);
  assign out   = lvl2;
  assign out_d = lvl2;

  // Pipeline copy; reset only clears the flop, the mux path is untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_mux8_1.sv
// Directed bench for mux8_1: expected values queued when stimulus is driven,
// popped and compared when the combinational and registered outputs are sampled.
module tb_mux8_1;

  logic       clk;
  logic       reset;
  logic [7:0] in_v;
  logic [2:0] sel_v;
  logic       out;
  logic       out_q;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic exp_out_q[$];
  logic exp_reg_q[$];

  mux8_1 dut (
    .clk   (clk),
    .reset (reset),
    .in    (in_v),
    .sel   (sel_v),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // One cycle: drive at negedge, check out, then check out_q after the posedge
  task automatic step(input logic [7:0] i, input logic [2:0] s, input logic r,
                      input bit chk_q, input string tag);
    logic [7:0] iv;
    logic       sel_bit;
    logic       expq;
    @(negedge clk);
    in_v  = i;
    sel_v = s;
    reset = r;
    iv      = i;
    sel_bit = iv[s];
    exp_out_q.push_back(sel_bit);
    exp_reg_q.push_back(r ? 1'b0 : sel_bit);
    #1;
    check({tag, "_out"}, out, exp_out_q.pop_front());
    @(posedge clk);
    #1;
    expq = exp_reg_q.pop_front();
    if (chk_q) check({tag, "_out_q"}, out_q, expq);
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] r8;
    reset = 1'b1;
    in_v  = 8'h00;
    sel_v = 3'd0;

    // Reset state
    step(8'h00, 3'd0, 1'b1, 1'b1, "rst_init");
    step(8'h5A, 3'd1, 1'b1, 1'b1, "rst_hold");

    // Select sweep over a fixed pattern
    pat = 8'b1010_0110;
    for (int s = 0; s < 8; s++) step(pat, 3'(s), 1'b0, 1'b1, "sweep");

    // One-hot walk: selected bit high, all other selects low
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 8; s++) step(8'(1 << k), 3'(s), 1'b0, 1'b0, "onehot");
    end

    // Random patterns with a cycling select
    for (int i = 0; i < 64; i++) begin
      r8 = 8'($urandom);
      step(r8, 3'(i), 1'b0, 1'b1, "rand");
    end

    // Reset clears out_q while out stays high, then out_q recovers
    step(8'hFF, 3'd3, 1'b0, 1'b1, "pre_rst");
    step(8'hFF, 3'd3, 1'b1, 1'b1, "rst_pulse");
    step(8'hFF, 3'd3, 1'b0, 1'b1, "rst_release");

    // Pipeline latency: out_q tracks the toggling out one edge later
    for (int i = 0; i < 8; i++) step(8'h80, (i % 2 == 0) ? 3'd7 : 3'd0, 1'b0, 1'b1, "latency");

    // Mid-operation reset with changing inputs
    for (int i = 0; i < 6; i++) begin
      r8 = 8'($urandom);
      step(r8, 3'($urandom_range(0, 7)), 1'b1, 1'b1, "mid_rst");
    end
    step(8'h01, 3'd0, 1'b0, 1'b1, "mid_rst_release");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
